// File: rtl/dmem_mmio_pkg.sv
// Shared constants for the data-side memory responder: region tag,
// MMIO register offsets and CONSOLE status bit positions.
package dmem_mmio_pkg;

    // Upper address nibble that selects the MMIO region
    localparam logic [3:0] MMIO_TAG = 4'hF;

    // MMIO register offsets (low 4 address bits)
    localparam logic [3:0] CYCLE_OFF = 4'h0;
    localparam logic [3:0] CONS_OFF  = 4'h4;
    localparam logic [3:0] HALT_OFF  = 4'h8;

    // CONSOLE status word layout
    localparam int ST_FULL    = 0;
    localparam int ST_EMPTY   = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 3;
    localparam int ST_CNT_W   = 5;

endpackage

// File: rtl/dmem_mmio_byte_fifo.sv
// Synchronous FIFO with registered storage and no fall-through.
// The head entry is presented on dout; dout reads 0 while empty.
// A pop on empty and a push on full without a pop are ignored.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    // Qualify requests: a push into a full FIFO is accepted only if a pop frees a slot
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Storage write; contents are not reset, validity is tracked by cnt
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Status flags and head data
    always_comb begin
        full  = (cnt == (AW+1)'(DEPTH));
        empty = (cnt == '0);
        count = cnt;
        dout  = empty ? '0 : mem[rptr];
    end

endmodule

// File: rtl/dmem_mmio.sv
// Data-side memory responder for the single-cycle cpu: word RAM plus an
// MMIO region (cycle counter, console byte FIFO, sticky halt flag).
// Reads are combinational from addr; stores take effect at the rising edge.
//
// Console handshake: cons_valid is high whenever the FIFO holds a byte and
// cons_data is the head byte; a byte is transferred on every rising edge
// where cons_valid && cons_ready. cons_valid does not depend on cons_ready,
// and cons_data/cons_valid stay stable until the byte is taken.
module dmem_mmio
    import dmem_mmio_pkg::*;
#(
    parameter int n          = 32,
    parameter int DEPTH      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memwrite,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] writedata,
    output logic [n-1:0] readdata,
    output logic [7:0]   cons_data,
    output logic         cons_valid,
    input  logic         cons_ready,
    output logic         halt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [n-1:0]  ram [DEPTH];
    logic [AW-1:0] ram_idx;
    logic [3:0]    off;
    logic          is_mmio;
    logic          cons_wr;
    logic          halt_wr;
    logic          pop_fire;
    logic [n-1:0]  cycle;
    logic          ovf;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [n-1:0]  status;
    logic          unused_bits;

    // Address decode and store strobes for each target
    always_comb begin
        is_mmio  = (addr[n-1:n-4] == MMIO_TAG);
        ram_idx  = addr[AW+1:2];
        off      = addr[3:0];
        cons_wr  = memwrite && is_mmio && (off == CONS_OFF);
        halt_wr  = memwrite && is_mmio && (off == HALT_OFF);
        pop_fire = cons_valid && cons_ready;
    end

    // Bits that the decode deliberately ignores (aliasing, byte offset, upper data)
    assign unused_bits = ^{addr, writedata};

    // RAM word write; contents survive reset
    always_ff @(posedge clk) begin
        if (memwrite && !is_mmio) begin
            ram[ram_idx] <= writedata;
        end
    end

    // Free-running cycle counter, sticky halt and sticky console overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle <= '0;
            halt  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            cycle <= cycle + 1'b1;
            if (halt_wr) halt <= 1'b1;
            if (cons_wr && fifo_full && !pop_fire) ovf <= 1'b1;
        end
    end

    byte_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cons_wr),
        .din   (writedata[7:0]),
        .pop   (pop_fire),
        .dout  (cons_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Console status word and stream valid
    always_comb begin
        status                                  = '0;
        status[ST_FULL]                         = fifo_full;
        status[ST_EMPTY]                        = fifo_empty;
        status[ST_OVF]                          = ovf;
        status[ST_CNT_LSB +: ST_CNT_W]          = ST_CNT_W'(fifo_count);
        cons_valid                              = !fifo_empty;
    end

    // Zero-latency load data mux
    always_comb begin
        readdata = '0;
        if (is_mmio) begin
            case (off)
                CYCLE_OFF: readdata    = cycle;
                CONS_OFF:  readdata    = status;
                HALT_OFF:  readdata[0] = halt;
                default:   readdata    = '0;
            endcase
        end else begin
            readdata = ram[ram_idx];
        end
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Self-checking bench for dmem_mmio: RAM aliasing, cycle counter,
// console FIFO fill/overflow/drain, halt, and reset behaviour.
module tb_dmem_mmio;

  localparam logic [31:0] A_CYCLE = 32'hFFFF_0000;
  localparam logic [31:0] A_CONS  = 32'hFFFF_0004;
  localparam logic [31:0] A_HALT  = 32'hFFFF_0008;
  localparam logic [31:0] A_UNMAP = 32'hFFFF_000C;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  cons_data;
  logic        cons_valid;
  logic        cons_ready;
  logic        halt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model_cyc;
  logic [31:0] ram_model [64];

  dmem_mmio dut (
    .clk        (clk),
    .reset      (reset),
    .memwrite   (memwrite),
    .addr       (addr),
    .writedata  (writedata),
    .readdata   (readdata),
    .cons_data  (cons_data),
    .cons_valid (cons_valid),
    .cons_ready (cons_ready),
    .halt       (halt)
  );

  // clock / reference cycle counter
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) model_cyc <= 32'd0;
    else       model_cyc <= model_cyc + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // inputs change at the falling edge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    writedata = d;
    memwrite  = 1'b1;
    tick();
    memwrite  = 1'b0;
  endtask

  // push the expectation, then pop and compare once readdata has settled
  task automatic do_load(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] e;
    addr     = a;
    memwrite = 1'b0;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check(tag, readdata, e);
  endtask

  function automatic logic [31:0] status_word(input bit full, input bit empty, input bit ov,
                                              input int cnt);
    logic [31:0] s;
    s = 32'd0;
    s[0] = full;
    s[1] = empty;
    s[2] = ov;
    s[7:3] = 5'(cnt);
    return s;
  endfunction

  initial begin
    int budget;
    reset      = 1'b1;
    memwrite   = 1'b0;
    addr       = 32'd0;
    writedata  = 32'd0;
    cons_ready = 1'b0;
    repeat (3) tick();

    // reset state, observed while reset is still held
    #1;
    check("rst_halt", {31'd0, halt}, 32'd0);
    check("rst_valid", {31'd0, cons_valid}, 32'd0);
    check("rst_cdata", {24'd0, cons_data}, 32'd0);
    do_load("rst_cycle", A_CYCLE, 32'd0);
    do_load("rst_status", A_CONS, status_word(0, 1, 0, 0));

    // cycle counter from release
    reset = 1'b0;
    do_load("cyc_0", A_CYCLE, 32'd0);
    repeat (10) tick();
    do_load("cyc_10", A_CYCLE, 32'd10);
    repeat (10) tick();
    do_load("cyc_20", A_CYCLE, 32'd20);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    do_load("cyc_after_pulse", A_CYCLE, 32'd0);
    do_store(A_CYCLE, 32'h1234_5678);
    do_load("cyc_wr_ignored", A_CYCLE, model_cyc);
    do_load("unmapped", A_UNMAP, 32'd0);
    do_store(A_UNMAP, 32'hFFFF_FFFF);
    do_load("unmapped_wr", A_UNMAP, 32'd0);

    // RAM store/load and aliasing
    do_store(32'h0000_0014, 32'h1234_5678);
    do_store(32'h0000_0010, 32'hDEAD_BEEF);
    do_load("ram_0x10", 32'h0000_0010, 32'hDEAD_BEEF);
    do_load("ram_alias_0x113", 32'h0000_0113, 32'hDEAD_BEEF);
    do_load("ram_0x14", 32'h0000_0014, 32'h1234_5678);
    for (int i = 8; i < 16; i++) begin
      ram_model[i] = $urandom;
      do_store({$urandom_range(0, 15'h7FFF), 6'(i), 2'(i)} & 32'h0FFF_FFFF | 32'(i) << 2,
               ram_model[i]);
    end
    for (int i = 8; i < 16; i++) begin
      do_load("ram_rand", (32'($urandom_range(0, 1023)) << 8) | (32'(i) << 2) | 32'($urandom_range(0, 3)),
              ram_model[i]);
    end

    // console fill with consumer stalled
    do_load("cons_empty", A_CONS, status_word(0, 1, 0, 0));
    do_store(A_CONS, 32'h0000_0041);
    #1;
    check("cons_valid_rise", {31'd0, cons_valid}, 32'd1);
    for (int b = 8'h42; b <= 8'h44; b++) do_store(A_CONS, 32'(b));
    do_load("cons_full", A_CONS, status_word(1, 0, 0, 4));
    do_store(A_CONS, 32'h0000_0045);
    do_load("cons_ovf", A_CONS, status_word(1, 0, 1, 4));
    #1;
    check("cons_head", {24'd0, cons_data}, 32'h41);

    // simultaneous push and pop while full
    cons_ready = 1'b1;
    do_store(A_CONS, 32'h0000_0046);
    cons_ready = 1'b0;
    do_load("cons_pushpop", A_CONS, status_word(1, 0, 1, 4));

    // drain with a randomly stalling consumer
    exp_q.push_back(32'h42);
    exp_q.push_back(32'h43);
    exp_q.push_back(32'h44);
    exp_q.push_back(32'h46);
    budget = 200;
    while (exp_q.size() > 0 && budget > 0) begin
      cons_ready = 1'($urandom_range(0, 1));
      #1;
      if (cons_valid && cons_ready) check("drain", {24'd0, cons_data}, exp_q.pop_front());
      tick();
      budget--;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    cons_ready = 1'b1;
    tick();
    #1;
    check("drain_valid", {31'd0, cons_valid}, 32'd0);
    do_load("drain_status", A_CONS, status_word(0, 1, 1, 0));
    cons_ready = 1'b0;

    // halt
    #1;
    check("halt_pre", {31'd0, halt}, 32'd0);
    do_store(A_HALT, 32'd0);
    #1;
    check("halt_set", {31'd0, halt}, 32'd1);
    do_load("halt_read", A_HALT, 32'd1);

    // reset discards FIFO contents and clears sticky flags
    do_store(A_CONS, 32'h0000_0077);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("post_rst_halt", {31'd0, halt}, 32'd0);
    check("post_rst_valid", {31'd0, cons_valid}, 32'd0);
    do_load("post_rst_status", A_CONS, status_word(0, 1, 0, 0));

    // stores during reset do not reach MMIO or the FIFO
    reset     = 1'b1;
    addr      = A_HALT;
    memwrite  = 1'b1;
    tick();
    addr      = A_CONS;
    writedata = 32'h55;
    tick();
    memwrite  = 1'b0;
    reset     = 1'b0;
    #1;
    check("rst_store_halt", {31'd0, halt}, 32'd0);
    check("rst_store_valid", {31'd0, cons_valid}, 32'd0);
    do_load("rst_store_cycle", A_CYCLE, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side memory responder for the single-cycle `cpu`. It is the slave end of the CPU's `memwrite`/`aluout`/`writedata`/`readdata` interface. It decodes each CPU data address into one of two regions:
- a word-addressed data RAM;
- a small memory-mapped I/O region: a free-running cycle counter, a console byte FIFO drained by an external consumer through a valid/ready handshake, and a sticky halt register.

Test benches and the top level use `halt` and the console stream to observe program results.

## Interface
Parameters:
- `n`, 32, data/address width.
- `DEPTH`, 64, RAM size in words (power of two).
- `FIFO_DEPTH`, 4, console FIFO entries (power of two, ≥2).

Ports:
- `clk` input 1: single clock; all state changes on rising edge.
- `reset` input 1: synchronous, active-high.
- `memwrite` input 1: CPU store strobe for the current cycle.
- `addr` input n: byte address, driven from CPU `aluout`.
- `writedata` input n: store data.
- `readdata` output n: load data, combinational from `addr`.
- `cons_data` output 8: head byte of the console FIFO.
- `cons_valid` output 1: FIFO non-empty.
- `cons_ready` input 1: consumer accepts the head byte.
- `halt` output 1: sticky halt flag.

## Operation
- Region decode:
  - `addr[31:28]==4'hF` selects MMIO.
  - Any other value selects RAM.
- RAM:
  - Index is `addr[$clog2(DEPTH)+1:2]`.
  - `addr[1:0]` and upper unused bits are ignored, so addresses alias modulo `4*DEPTH`.
  - A store writes the full word at the edge when `memwrite=1`.
  - Reset does not clear RAM.
- MMIO map (only the low 4 bits of `addr` are decoded; others ignored within the region):
  - `0xFFFF_0000` CYCLE, read-only. Returns the counter; writes are ignored.
  - `0xFFFF_0004` CONSOLE.
    - Store: pushes `writedata[7:0]`. If the FIFO is full and no pop happens in the same cycle, the byte is dropped and sticky `ovf` is set.
    - Load: returns status. Bit0 full, bit1 empty, bit2 `ovf`, bits[7:3] count. All other bits are 0.
  - `0xFFFF_0008` HALT.
    - Store of any value sets `halt=1` until reset.
    - Load returns `{31'b0,halt}`.
  - `0xFFFF_000C` unmapped: reads 0, writes ignored.
- Console FIFO:
  - Pop occurs when `cons_valid && cons_ready`.
  - Push and pop in the same cycle are both honoured: count is unchanged, including when full, and then no overflow occurs.
  - A pop when empty is a no-op.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - There is no fall-through: a byte pushed at edge k is visible on `cons_data` after edge k.
- `cons_data` equals the head entry whenever `cons_valid=1`. It is don't-care otherwise, but the bench may expect 0 after reset.

## Timing
- Reset values:
  - `halt=0`, `cons_valid=0`, `cons_data=0`.
  - Counter = 0, `ovf=0`, FIFO pointers and count = 0.
  - `readdata` follows `addr` combinationally even during reset. RAM reads return the old contents; MMIO reads return the reset values.
- Reads have zero latency: `readdata` is valid in the same cycle as `addr`, as the single-cycle CPU requires.
- Writes have one-edge latency. A load in the cycle after a store to the same address returns the new value.
- Cycle counter:
  - Reads 0 in the first cycle with `reset=0`.
  - Increments by 1 every edge with `reset=0`.
  - Wraps from `2^n-1` to 0.
- A store that coincides with `reset=1` is ignored for the MMIO registers and the FIFO.
- Reset mid-stream discards FIFO contents: `cons_valid` is 0 after the reset edge.
- `halt` asserts one edge after the store. `cons_valid` rises one edge after the first push into an empty FIFO.

## Structure
- Package `dmem_mmio_pkg` holds:
  - MMIO region tag `4'hF`;
  - register offsets (`CYCLE_OFF`, `CONS_OFF`, `HALT_OFF`);
  - status bit positions.
- Sub-module `byte_fifo`: a parameterised synchronous FIFO with push/pop, full/empty/count outputs and a head-data output.
- The top level contains the decoder, RAM array, counter, `halt` and `ovf` registers, and the readdata mux.

## Test plan
- Store `0xDEADBEEF` to `0x0000_0010`, then load `0x0000_0010` and `0x0000_0113` (alias with `DEPTH=64`) → both return `0xDEADBEEF`; `0x0000_0014` is unaffected.
- Release reset, then load CYCLE at cycles 0 and 10 → returns 0 and 10. Pulse reset at cycle 20 → returns 0 in the next cycle.
- With `cons_ready=0`, store bytes `0x41..0x45` to CONSOLE → status reads full=1 and count=4. `ovf=1` after the 5th store. `cons_data=0x41`.
- From full, assert `cons_ready` and push `0x46` in the same cycle → count stays 4, `ovf` unchanged. The drained sequence is `0x42,0x43,0x44,0x46`, after which `cons_valid=0` and empty=1.
- Store `0` to HALT → `halt=1` after the edge and HALT reads 1. Reset → `halt=0`, `cons_valid=0`, `ovf=0`.
